rsc_frame_encoder: RTL
======================

// Module: rsc_frame_encoder
// PURPOSE
//  Rate-1/2 recursive systematic convolutional (RSC) encoder with trellis termination.
//  It is the transmit-side counterpart of the turbo_decode path-metric/survivor logic.
//  Accepts one FRAME_LEN-bit message word and emits FRAME_LEN+2 {sys,par} symbols,
//  the last two being tail symbols, so the decoder trellis starts and ends in state 00.
// PARAMETERS
//  FRAME_LEN  4  message bits per frame (>=1); 4 matches the decoder's 4-bit c_survive
//  CNT_W      3  symbol counter width; must satisfy 2^CNT_W > FRAME_LEN+1
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous reset, active-high
//  s_valid    in   1          message word valid
//  s_ready    out  1          encoder can accept a word (IDLE only)
//  s_data     in   FRAME_LEN  message; bit FRAME_LEN-1 is encoded first (MSB first)
//  m_valid    out  1          output symbol valid
//  m_ready    in   1          downstream accepts symbol
//  m_sys      out  1          systematic bit (message bit, or tail input bit)
//  m_par      out  1          parity bit
//  m_last     out  1          high with the final (second tail) symbol of a frame
//  busy       out  1          frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE, shift reg {s1,s0}=00, cnt=0, s_ready=0 during rst then 1 in IDLE,
//   m_valid=0, m_sys=0, m_par=0, m_last=0, busy=0.
//  Encoder core (s1 = most recent): data bit u gives a = u^s1^s0, par = a^s0,
//   sys = u, next {s1,s0} = {a,s1}. Feedback is 1+D+D^2 (7); feedforward is 1+D^2 (5).
//  Tail bit: u = s1^s0, which forces a = 0. Output sys = u, par = s0.
//   Two tail symbols always return {s1,s0} to 00.
//  FSM IDLE -> DATA -> TAIL -> IDLE.
//   IDLE: s_ready=1. When s_valid&s_ready: latch s_data into the shift buffer,
//    clear {s1,s0} and cnt, go to DATA.
//   DATA: present symbol for buffer MSB; on m_valid&m_ready shift the buffer left,
//    update {s1,s0} and increment cnt. After the handshake with cnt=FRAME_LEN-1, go to TAIL.
//   TAIL: two tail symbols. m_last=1 on the second one. A handshake on it returns to IDLE.
//  Output register: m_sys/m_par/m_last are registered.
//   m_valid rises the cycle after the input handshake (latency 1).
//  Backpressure: while m_valid&!m_ready, m_sys/m_par/m_last hold stable and the
//   encoder state does not advance.
//  Throughput is 1 symbol/clk with m_ready high. s_ready returns 1 the cycle after the
//   last handshake, giving a 1-cycle bubble between frames. A frame is FRAME_LEN+2 symbols.
//  s_valid in a non-IDLE state is ignored; s_data is sampled only at the input handshake.
//  The encoder never drops m_valid mid-frame; it is continuous from first to last symbol.
//  rst mid-frame: abort immediately, drop the frame, all outputs take reset values next cycle.
//  No arithmetic beyond XOR. cnt never exceeds FRAME_LEN+1 and clears on each new frame.
// TESTING
//  T1 s_data=4'b1011, m_ready=1 -> sys 1,0,1,1,0,1; par 1,1,0,0,1,1;
//     m_last only on the 6th symbol; s_ready=1 on cycle 7.
//  T2 s_data=4'b1000 -> sys 1,0,0,0,1,1; par 1,1,1,0,0,1; final {s1,s0}=00.
//  T3 s_data=4'b0000 -> 6 symbols with sys=0 and par=0; m_last on the 6th.
//  T4 T1 with m_ready low for 3 cycles at symbol 3 -> symbol 3 ({1,0}) held stable,
//     same 6-symbol sequence, frame ends 3 cycles later.
//  T5 assert rst after 2nd symbol of T1 -> next cycle m_valid=0, busy=0, s_ready=1
//     after rst drops; a new frame 4'b1000 then encodes exactly as in T2.
//  T6 back-to-back 4'b1011 then 4'b1000 with s_valid held high -> second frame accepted
//     only in IDLE; outputs match T1 then T2, with a 1-cycle m_valid gap between them.

Source files
------------

// File: rtl/rsc_frame_encoder.sv
// Rate-1/2 recursive systematic convolutional encoder (feedback 7, feedforward 5)
// with two-symbol trellis termination. One FRAME_LEN-bit word in, FRAME_LEN+2
// {sys,par} symbols out, MSB of the word first, trellis ends in state 00.
module rsc_frame_encoder #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [FRAME_LEN-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_sys,
  output logic                 m_par,
  output logic                 m_last,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  // Index of the last data symbol and of the second tail symbol.
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(FRAME_LEN + 1);

  state_t               state, state_nxt;
  logic [FRAME_LEN-1:0] msg;      // remaining message bits, MSB = bit of the presented symbol
  logic                 s1, s0;   // trellis state before the presented symbol (s1 = most recent)
  logic [CNT_W-1:0]     cnt;      // index of the presented symbol within the frame

  logic                 accept, take;
  logic                 cur_a, ns1, ns0;
  logic [CNT_W-1:0]     cnt_inc;
  logic [FRAME_LEN-1:0] msg_shl;
  logic                 nxt_is_data, nxt_u, nxt_a, nxt_par;

  assign accept = s_valid & s_ready;
  assign take   = m_valid & m_ready;

  // Advance the trellis by the presented symbol, then form the following symbol
  // so it can be registered directly into the output stage.
  always_comb begin
    cur_a       = 1'b0;
    if (state == DATA)
      cur_a = msg[FRAME_LEN-1] ^ s1 ^ s0;   // tail input forces the feedback sum to 0
    ns1         = cur_a;
    ns0         = s1;
    cnt_inc     = cnt + CNT_W'(1);
    msg_shl     = msg << 1;
    nxt_is_data = (state == DATA) && (cnt != DATA_LAST);
    nxt_u       = nxt_is_data ? msg_shl[FRAME_LEN-1] : (ns1 ^ ns0);
    nxt_a       = nxt_is_data ? (nxt_u ^ ns1 ^ ns0) : 1'b0;
    nxt_par     = nxt_a ^ ns0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: leave a phase only on the handshake of its last symbol.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = DATA;
      DATA:    if (take && cnt == DATA_LAST) state_nxt = TAIL;
      TAIL:    if (take && cnt == TAIL_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept words only in IDLE and never while reset is applied.
  always_comb begin
    s_ready = (state == IDLE) && !rst;
    busy    = (state != IDLE);
  end

  // Datapath and registered output symbol; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg     <= '0;
      s1      <= 1'b0;
      s0      <= 1'b0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_sys   <= 1'b0;
      m_par   <= 1'b0;
      m_last  <= 1'b0;
    end else if (accept) begin
      // From state 00 the first symbol is {u,u}.
      msg     <= s_data;
      s1      <= 1'b0;
      s0      <= 1'b0;
      cnt     <= '0;
      m_valid <= 1'b1;
      m_sys   <= s_data[FRAME_LEN-1];
      m_par   <= s_data[FRAME_LEN-1];
      m_last  <= 1'b0;
    end else if (take) begin
      s1  <= ns1;
      s0  <= ns0;
      msg <= msg_shl;
      if (cnt == TAIL_LAST) begin
        // Frame complete; cnt stays at its maximum until the next word.
        m_valid <= 1'b0;
        m_sys   <= 1'b0;
        m_par   <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        cnt    <= cnt_inc;
        m_sys  <= nxt_u;
        m_par  <= nxt_par;
        m_last <= (cnt_inc == TAIL_LAST);
      end
    end
  end

endmodule
